serial_feeder: RTL
==================

# serial_feeder

Upstream stimulus stage for the register-fanout test datapath. Accepts parallel words on a valid/ready handshake, buffers them in a small FIFO, and shifts each word out LSB-first, one bit per clock, on a single-bit registered output. That output drives the data input of the launching flop, which then fans out to the buffer chain and capture registers. Back-to-back words serialize with no idle cycle between them.

## Interface
- WIDTH, 8: bits per word; ≥2.
- DEPTH, 4: FIFO entries; power of two, ≥2.
- LVL_W, $clog2(DEPTH+1): width of `level`; derived, not overridden.

Ports (one clock; reset is asynchronous and active-high):
- clk  in  1  single clock; all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_data  in  WIDTH  word to serialize.
- in_valid  in  1  producer has a word.
- in_ready  out  1  FIFO not full.
- ser_out  out  1  serial bit, feeds the launch flop's D.
- ser_valid  out  1  `ser_out` carries a live bit.
- busy  out  1  shifter active or FIFO non-empty.
- level  out  LVL_W  FIFO occupancy, excluding the word in the shifter.

## Operation
- Reset values: `ser_out`=0, `ser_valid`=0, `busy`=0, `level`=0, `in_ready`=1, FSM=IDLE, FIFO pointers=0.
- Push: occurs when `in_valid && in_ready` at a rising edge. `in_ready` = (level != DEPTH) and is derived from registered occupancy only, with no combinational path from the pop. When full, a same-cycle pop does not admit a push.
- FSM states: IDLE, SHIFT.
  - IDLE: if level>0 at an edge, pop the head word into the shift register, set bitcnt=WIDTH-1, and go to SHIFT. Otherwise stay.
  - SHIFT: `ser_out` = shreg[0], `ser_valid`=1. Each edge shifts right and decrements bitcnt.
  - At bitcnt==0: if level>0, reload from the FIFO on the same edge and stay in SHIFT (no gap). Otherwise go to IDLE.
- IDLE outputs: `ser_out`=0, `ser_valid`=0.
- Simultaneous push and pop on a non-full FIFO: `level` is unchanged and both pointers advance.
- Pointers: log2(DEPTH) bits, natural wrap-around. Full and empty are resolved by `level`, not by pointer comparison.
- `busy` = (state==SHIFT) || (level!=0).
- Reset mid-word: the partial word is discarded, all buffered words are dropped, and outputs go to reset values immediately (asynchronous). Serialization restarts only from new pushes after `rst` deasserts.

## Timing
- Word accepted at edge N into an empty, idle feeder: loaded at edge N+1. `ser_valid`=1 for the cycles following edges N+1 … N+WIDTH, with bit i present after edge N+1+i.
- Steady-state throughput: one word per WIDTH cycles, 100% `ser_valid` duty while the FIFO is non-empty.
- `level` and `in_ready` update at the edge following a push or pop.
- All outputs are registered, or decoded from registers only. There is no input-to-output combinational path.

## Structure
- Package `serial_feeder_pkg`: `feeder_state_t` enum {IDLE, SHIFT}, default WIDTH/DEPTH constants.
- Sub-module `feeder_fifo`:
  - Parameterized WIDTH/DEPTH register-array FIFO with push/pop/level.
  - Pop is enabled by the FSM.
  - Head data is read combinationally from the read pointer.
- Top level contains the FSM, shift register, and bit counter.

## Test plan
- Reset: assert `rst` asynchronously mid-cycle → `ser_out`=0, `ser_valid`=0, `busy`=0, `level`=0, `in_ready`=1 before the next edge.
- Single word: push 0xA5 at edge 0 → `ser_valid` high after edges 1–8; `ser_out` sequence 1,0,1,0,0,1,0,1; `ser_valid`=0 after edge 9.
- Back-to-back: push 0xFF then 0x00 on consecutive edges → 16 contiguous `ser_valid` cycles; eight 1s then eight 0s, no gap.
- Full: with the shifter busy, push 0x01–0x05 on consecutive edges → `level` reaches 4 and `in_ready`=0. 0x05 is held by the producer and accepted the edge after the next reload. Output order is 0x01…0x05.
- Reset mid-word: push 0x3C and 0xC3, assert `rst` after 3 bits of 0x3C → outputs zeroed and `level`=0. After release, push 0x81 → only 0x81 serializes, 8 cycles later.
- Wrap: stream 10 words 0x10–0x19 with `in_valid` held high, DEPTH=4 → pointers wrap twice; 80 bits out in order, no loss or duplication.

Source files
------------

// File: rtl/serial_feeder_pkg.sv
// Shared types and default sizing for the serial feeder and its FIFO.
package serial_feeder_pkg;

  localparam int unsigned DefaultWidth = 8;
  localparam int unsigned DefaultDepth = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } feeder_state_t;

endpackage

// File: rtl/feeder_fifo.sv
// Register-array FIFO; occupancy tracked by a level counter so pointers wrap freely.
module feeder_fifo
  import serial_feeder_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth,
  parameter int unsigned DEPTH = DefaultDepth,
  localparam int unsigned LVL_W = $clog2(DEPTH + 1),
  localparam int unsigned PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic [LVL_W-1:0] level_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic             do_push;
  logic             do_pop;

  always_comb begin
    // Full/empty come from registered occupancy, so a pop never frees a slot in the same cycle.
    do_push  = push_i && (level_q != LVL_W'(DEPTH));
    do_pop   = pop_i && (level_q != '0);
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = wdata_i;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    if (do_push && !do_pop) begin
      level_d = level_q + LVL_W'(1);
    end else if (!do_push && do_pop) begin
      level_d = level_q - LVL_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign level_o = level_q;

endmodule

// File: rtl/serial_feeder.sv
// Buffers parallel words and shifts them out LSB-first, one bit per clock, with no
// idle cycle between consecutive words.
module serial_feeder
  import serial_feeder_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth,
  parameter int unsigned DEPTH = DefaultDepth,
  localparam int unsigned LVL_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             busy,
  output logic [LVL_W-1:0] level
);

  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  feeder_state_t    state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CntW-1:0]  bitcnt_q, bitcnt_d;
  logic [WIDTH-1:0] head;
  logic             push;
  logic             pop;

  feeder_fifo #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .push_i (push),
    .wdata_i(in_data),
    .pop_i  (pop),
    .rdata_o(head),
    .level_o(level)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      shreg_q  <= '0;
      bitcnt_q <= '0;
    end else begin
      state_q  <= state_d;
      shreg_q  <= shreg_d;
      bitcnt_q <= bitcnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    shreg_d  = shreg_q;
    bitcnt_d = bitcnt_q;
    pop      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (level != '0) begin
          pop      = 1'b1;
          shreg_d  = head;
          bitcnt_d = CntW'(WIDTH - 1);
          state_d  = SHIFT;
        end
      end
      SHIFT: begin
        if (bitcnt_q != '0) begin
          shreg_d  = shreg_q >> 1;
          bitcnt_d = bitcnt_q - CntW'(1);
        end else if (level != '0) begin
          // Reload on the last-bit edge keeps the serial stream gap-free.
          pop      = 1'b1;
          shreg_d  = head;
          bitcnt_d = CntW'(WIDTH - 1);
        end else begin
          shreg_d = shreg_q >> 1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (level != LVL_W'(DEPTH));
    push      = in_valid && in_ready;
    ser_valid = (state_q == SHIFT);
    ser_out   = ser_valid && shreg_q[0];
    busy      = ser_valid || (level != '0);
  end

endmodule
